// File: rtl/vga_regs_pkg.sv
// Shared register map, address constants and FSM state types
// for the VGA text controller CPU read-back path.
package vga_regs_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_ADDR_LO = 3'd1;
    localparam logic [2:0] REG_ADDR_HI = 3'd2;
    localparam logic [2:0] REG_DATA    = 3'd3;
    localparam logic [2:0] REG_IEN     = 3'd4;
    localparam logic [2:0] REG_INTR    = 3'd5;
    localparam logic [2:0] REG_HSCROLL = 3'd6;
    localparam logic [2:0] REG_VSCROLL = 3'd7;

    localparam logic [13:0] RAM_SIZE     = 14'h1900;
    localparam logic [13:0] BGCOLOR_ADDR = 14'h1FFE;
    localparam logic [13:0] FGCOLOR_ADDR = 14'h1FFF;
    localparam logic [13:0] ADDR_WRAP    = 14'h2000;

    typedef enum logic [1:0] {
        B_IDLE,
        B_DRIVE,
        B_RETIRE
    } bus_state_e;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_REQ,
        PF_WAIT
    } pf_state_e;

    // Auto-increment target, wrapping inside the 8 KiB VRAM window
    function automatic logic [13:0] next_addr(
        input logic [13:0] a,
        input logic [7:0]  inc,
        input logic        neg
    );
        logic [13:0] i14;
        i14 = {6'b0, inc};
        if (!neg)
            return (a + i14) & (ADDR_WRAP - 14'd1);
        else if (a >= i14)
            return a - i14;
        else
            return a + ADDR_WRAP - i14;
    endfunction

endpackage

// File: rtl/vga_bus_reader_if.sv
// CPU bus and framebuffer read-port signal bundle
// for the VGA read-back path.
interface vga_bus_reader_if;

    logic        CLK_CPU;
    logic        EN;
    logic        RW;
    logic [2:0]  REG;
    logic [7:0]  DATA_OUT;
    logic        DIR;

    logic        fb_req;
    logic [13:0] fb_addr;
    logic        fb_grant;
    logic [7:0]  fb_rdata;

    modport master (
        input  CLK_CPU, EN, RW, REG,
        input  fb_grant, fb_rdata,
        output DATA_OUT, DIR,
        output fb_req, fb_addr
    );

    modport slave (
        output CLK_CPU, EN, RW, REG,
        output fb_grant, fb_rdata,
        input  DATA_OUT, DIR,
        input  fb_req, fb_addr
    );

endinterface

// File: rtl/vga_bus_reader_sync.sv
// Multi-flop synchronizer for asynchronous CPU bus inputs,
// with rise/fall detection on bit 0.
module bus_sync #(
    parameter int            N       = 1,
    parameter int            STAGES  = 2,
    parameter logic [N-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         rise_o,
    output logic         fall_o
);

    logic [N-1:0] sync_q [STAGES];
    logic         prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++)
                sync_q[i] <= RST_VAL;
            prev_q <= RST_VAL[0];
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1][0];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o[0] & ~prev_q;
    assign fall_o = ~q_o[0] & prev_q;

endmodule

// File: rtl/vga_bus_reader.sv
// 6502 read-back path: register mux, DATA prefetch buffer,
// framebuffer fetch and post-read address advance.
module vga_bus_reader #(
    parameter logic [13:0] RAM_SIZE    = vga_regs_pkg::RAM_SIZE,
    parameter int          FB_LATENCY  = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CLK_FAST,
    input  logic              RESET,
    vga_bus_reader_if.master  bus,
    input  logic [7:0]        ctrl_value,
    input  logic [7:0]        ien_value,
    input  logic [7:0]        intr_value,
    input  logic [7:0]        hscroll_value,
    input  logic [7:0]        vscroll_value,
    input  logic [7:0]        bgcolor,
    input  logic [7:0]        fgcolor,
    input  logic [13:0]       address_reg,
    input  logic              addr_load,
    input  logic [7:0]        increment,
    input  logic              increment_neg,
    output logic              addr_adv,
    output logic [13:0]       addr_next,
    output logic [7:0]        intr_clr,
    output logic              underrun
);

    import vga_regs_pkg::*;

    localparam int CW = $clog2(FB_LATENCY + 1);

    logic [5:0] s_bus;
    logic       cpu_rise;
    logic       cpu_fall;
    logic       s_en;
    logic       s_rw;
    logic [2:0] s_reg;
    logic       read_start;

    // EN idles high (deselected) so reset never looks like a read
    bus_sync #(
        .N       (6),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (6'b000010)
    ) u_sync (
        .clk_i  (CLK_FAST),
        .rst_i  (RESET),
        .d_i    ({bus.REG, bus.RW, bus.EN, bus.CLK_CPU}),
        .q_o    (s_bus),
        .rise_o (cpu_rise),
        .fall_o (cpu_fall)
    );

    assign s_en       = s_bus[1];
    assign s_rw       = s_bus[2];
    assign s_reg      = s_bus[5:3];
    assign read_start = cpu_rise & ~s_en & s_rw;

    bus_state_e  bst_q, bst_d;
    logic [7:0]  data_q, data_d;
    logic        dir_q, dir_d;
    logic [2:0]  reg_q, reg_d;
    logic [7:0]  ilat_q, ilat_d;
    logic        urun_q, urun_d;
    logic        adv_q, adv_d;
    logic [13:0] next_q, next_d;
    logic [7:0]  clr_q, clr_d;
    logic        adv_fire;
    logic [13:0] adv_addr;
    logic [7:0]  mux;

    pf_state_e   pst_q, pst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [13:0] fa_q, fa_d;
    logic [7:0]  pdat_q, pdat_d;
    logic        pval_q, pval_d;
    logic        init_q;
    logic        start;
    logic [13:0] saddr;

    assign adv_addr = next_addr(address_reg, increment, increment_neg);

    always_comb begin
        mux = 8'h00;
        unique case (s_reg)
            REG_CTRL:    mux = ctrl_value;
            REG_ADDR_LO: mux = {3'b0, address_reg[4:0]};
            REG_ADDR_HI: mux = address_reg[12:5];
            REG_DATA:    mux = pdat_q;
            REG_IEN:     mux = ien_value;
            REG_INTR:    mux = intr_value;
            REG_HSCROLL: mux = hscroll_value;
            REG_VSCROLL: mux = vscroll_value;
        endcase
    end

    always_comb begin
        bst_d    = bst_q;
        data_d   = data_q;
        dir_d    = dir_q;
        reg_d    = reg_q;
        ilat_d   = ilat_q;
        urun_d   = urun_q;
        next_d   = next_q;
        adv_d    = 1'b0;
        clr_d    = 8'h00;
        adv_fire = 1'b0;
        case (bst_q)
            B_IDLE: begin
                if (read_start) begin
                    bst_d  = B_DRIVE;
                    data_d = mux;
                    dir_d  = 1'b0;
                    reg_d  = s_reg;
                    ilat_d = intr_value;
                    if (s_reg == REG_DATA && !pval_q)
                        urun_d = 1'b1;
                end
            end
            B_DRIVE: begin
                if (cpu_fall || s_en) begin
                    bst_d = B_RETIRE;
                    dir_d = 1'b1;
                end
            end
            B_RETIRE: begin
                bst_d = B_IDLE;
                if (reg_q == REG_INTR)
                    clr_d = ilat_q;
                // A concurrent writer load owns the pointer this cycle
                if (reg_q == REG_DATA && increment != 8'h00 && !addr_load) begin
                    adv_fire = 1'b1;
                    adv_d    = 1'b1;
                    next_d   = adv_addr;
                end
            end
            default: bst_d = B_IDLE;
        endcase
    end

    always_ff @(posedge CLK_FAST or posedge RESET) begin
        if (RESET) begin
            bst_q  <= B_IDLE;
            data_q <= 8'h00;
            dir_q  <= 1'b1;
            reg_q  <= 3'd0;
            ilat_q <= 8'h00;
            urun_q <= 1'b0;
            adv_q  <= 1'b0;
            next_q <= 14'h0000;
            clr_q  <= 8'h00;
        end else begin
            bst_q  <= bst_d;
            data_q <= data_d;
            dir_q  <= dir_d;
            reg_q  <= reg_d;
            ilat_q <= ilat_d;
            urun_q <= urun_d;
            adv_q  <= adv_d;
            next_q <= next_d;
            clr_q  <= clr_d;
        end
    end

    assign start = init_q | addr_load | adv_fire;
    assign saddr = adv_fire ? adv_addr : address_reg;

    always_comb begin
        pst_d  = pst_q;
        cnt_d  = cnt_q;
        fa_d   = fa_q;
        pdat_d = pdat_q;
        pval_d = pval_q;
        case (pst_q)
            PF_REQ: begin
                if (bus.fb_grant) begin
                    pst_d = PF_WAIT;
                    cnt_d = CW'(1);
                end
            end
            PF_WAIT: begin
                if (cnt_q == CW'(FB_LATENCY)) begin
                    pdat_d = bus.fb_rdata;
                    pval_d = 1'b1;
                    pst_d  = PF_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: pst_d = PF_IDLE;
        endcase
        // A new start overrides, dropping any in-flight read
        if (start) begin
            pval_d = 1'b0;
            cnt_d  = '0;
            if (saddr == BGCOLOR_ADDR) begin
                pdat_d = bgcolor;
                pval_d = 1'b1;
                pst_d  = PF_IDLE;
            end else if (saddr == FGCOLOR_ADDR) begin
                pdat_d = fgcolor;
                pval_d = 1'b1;
                pst_d  = PF_IDLE;
            end else if (saddr >= RAM_SIZE) begin
                pdat_d = 8'h00;
                pval_d = 1'b1;
                pst_d  = PF_IDLE;
            end else begin
                fa_d  = saddr;
                pst_d = PF_REQ;
            end
        end
    end

    always_ff @(posedge CLK_FAST or posedge RESET) begin
        if (RESET) begin
            pst_q  <= PF_IDLE;
            cnt_q  <= '0;
            fa_q   <= 14'h0000;
            pdat_q <= 8'h00;
            pval_q <= 1'b0;
            init_q <= 1'b1;
        end else begin
            pst_q  <= pst_d;
            cnt_q  <= cnt_d;
            fa_q   <= fa_d;
            pdat_q <= pdat_d;
            pval_q <= pval_d;
            init_q <= 1'b0;
        end
    end

    assign bus.DATA_OUT = data_q;
    assign bus.DIR      = dir_q;
    assign bus.fb_req   = (pst_q == PF_REQ);
    assign bus.fb_addr  = fa_q;
    assign addr_adv     = adv_q;
    assign addr_next    = next_q;
    assign intr_clr     = clr_q;
    assign underrun     = urun_q;

endmodule

// File: tb/tb_vga_bus_reader.sv
// Directed bench for vga_bus_reader: register table, DATA prefetch,
// wrap/special addresses, underrun, fetch abort and async reset.
module tb_vga_bus_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ctrl_value = 8'h11;
    logic [7:0]  ien_value = 8'h22;
    logic [7:0]  intr_value = 8'h00;
    logic [7:0]  hscroll_value = 8'h33;
    logic [7:0]  vscroll_value = 8'h44;
    logic [7:0]  bgcolor = 8'h0B;
    logic [7:0]  fgcolor = 8'hF0;
    logic [13:0] address_reg;
    logic [13:0] areg_q;
    logic        load_req = 1'b0;
    logic [13:0] load_val = 14'h0;
    logic [7:0]  increment = 8'd1;
    logic        increment_neg = 1'b0;
    logic        addr_adv;
    logic [13:0] addr_next;
    logic [7:0]  intr_clr;
    logic        underrun;
    logic        grant_en = 1'b1;

    logic [7:0]  mem [0:8191];
    logic [7:0]  st0, st1;

    int adv_cnt = 0;
    int req_cnt = 0;
    int clr_cnt = 0;
    int dir0_cnt = 0;
    logic [7:0] clr_last = 8'h00;

    int total = 0;
    int passed = 0;

    vga_bus_reader_if bif();

    vga_bus_reader dut (
        .CLK_FAST      (clk),
        .RESET         (rst),
        .bus           (bif),
        .ctrl_value    (ctrl_value),
        .ien_value     (ien_value),
        .intr_value    (intr_value),
        .hscroll_value (hscroll_value),
        .vscroll_value (vscroll_value),
        .bgcolor       (bgcolor),
        .fgcolor       (fgcolor),
        .address_reg   (address_reg),
        .addr_load     (load_req),
        .increment     (increment),
        .increment_neg (increment_neg),
        .addr_adv      (addr_adv),
        .addr_next     (addr_next),
        .intr_clr      (intr_clr),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    assign address_reg  = load_req ? load_val : areg_q;
    assign bif.fb_grant = grant_en;
    assign bif.fb_rdata = st1;

    // Writer model, BRAM model (2-cycle latency) and event counters
    always @(posedge clk) begin
        if (rst)
            areg_q <= 14'h0005;
        else if (load_req)
            areg_q <= load_val;
        else if (addr_adv)
            areg_q <= addr_next;
        st0 <= mem[bif.fb_addr[12:0]];
        st1 <= st0;
        if (addr_adv) adv_cnt <= adv_cnt + 1;
        if (bif.fb_req) req_cnt <= req_cnt + 1;
        if (intr_clr != 8'h00) begin
            clr_cnt  <= clr_cnt + 1;
            clr_last <= intr_clr;
        end
        if (!bif.DIR) dir0_cnt <= dir0_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cpu_cycle(input logic [2:0] r, input logic rw,
                             output logic [7:0] d, output logic dmid,
                             output logic dend);
        @(negedge clk);
        bif.REG = r;
        bif.RW  = rw;
        bif.EN  = 1'b0;
        @(negedge clk);
        bif.CLK_CPU = 1'b1;
        repeat (6) @(negedge clk);
        d    = bif.DATA_OUT;
        dmid = bif.DIR;
        bif.CLK_CPU = 1'b0;
        repeat (6) @(negedge clk);
        dend = bif.DIR;
        bif.EN = 1'b1;
        bif.RW = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_addr(input logic [13:0] a);
        @(negedge clk);
        load_req = 1'b1;
        load_val = a;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    typedef struct {
        logic [2:0] r;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0] d;
        logic dm, de;
        int snap, snap2;

        for (int i = 0; i < 8192; i++)
            mem[i] = 8'(i * 7 + 3);
        mem[5]     = 8'h41;
        mem[6]     = 8'h42;
        mem[2]     = 8'h22;
        mem[16]    = 8'h90;
        mem[18]    = 8'h92;
        mem[256]   = 8'hA5;
        mem[512]   = 8'h5A;
        mem[2748]  = 8'hBC;

        tbl[0] = '{3'd0, 8'h11, "reg_ctrl"};
        tbl[1] = '{3'd1, 8'h1C, "reg_addr_lo"};
        tbl[2] = '{3'd2, 8'h55, "reg_addr_hi"};
        tbl[3] = '{3'd3, 8'hBC, "reg_data"};
        tbl[4] = '{3'd4, 8'h22, "reg_ien"};
        tbl[5] = '{3'd5, 8'h81, "reg_intr"};
        tbl[6] = '{3'd6, 8'h33, "reg_hscroll"};
        tbl[7] = '{3'd7, 8'h44, "reg_vscroll"};

        bif.CLK_CPU = 1'b0;
        bif.EN      = 1'b1;
        bif.RW      = 1'b1;
        bif.REG     = 3'd0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'h0, bif.DATA_OUT}, 32'h0);
        chk("rst_dir", {31'h0, bif.DIR}, 32'h1);
        chk("rst_fb_req", {31'h0, bif.fb_req}, 32'h0);
        chk("rst_fb_addr", {18'h0, bif.fb_addr}, 32'h0);
        chk("rst_addr_adv", {31'h0, addr_adv}, 32'h0);
        chk("rst_addr_next", {18'h0, addr_next}, 32'h0);
        chk("rst_intr_clr", {24'h0, intr_clr}, 32'h0);
        chk("rst_underrun", {31'h0, underrun}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Initial prefetch of address 5, then two sequential DATA reads
        snap = adv_cnt;
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_fb5", {24'h0, d}, 32'h41);
        chk("dir_drive", {31'h0, dm}, 32'h0);
        chk("dir_retire", {31'h0, de}, 32'h1);
        chk("adv_once", adv_cnt - snap, 1);
        chk("adv_next6", {18'h0, addr_next}, 32'h6);
        repeat (10) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_fb6", {24'h0, d}, 32'h42);

        // Negative increment wrapping into the colour registers
        increment = 8'd3;
        increment_neg = 1'b1;
        load_addr(14'h0002);
        repeat (10) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_fb2", {24'h0, d}, 32'h22);
        chk("neg_wrap_next", {18'h0, addr_next}, 32'h1FFF);
        snap = req_cnt;
        repeat (4) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_fgcolor", {24'h0, d}, 32'hF0);
        chk("next_1ffc", {18'h0, addr_next}, 32'h1FFC);
        repeat (4) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_beyond_ram", {24'h0, d}, 32'h00);
        chk("special_no_req", req_cnt - snap, 0);
        chk("no_underrun_yet", {31'h0, underrun}, 32'h0);

        // Interrupt read-to-clear
        intr_value = 8'h81;
        snap = clr_cnt;
        snap2 = adv_cnt;
        cpu_cycle(3'd5, 1'b1, d, dm, de);
        chk("intr_data", {24'h0, d}, 32'h81);
        chk("intr_clr_once", clr_cnt - snap, 1);
        chk("intr_clr_val", {24'h0, clr_last}, 32'h81);
        chk("intr_no_adv", adv_cnt - snap2, 0);

        // Stalled grant: stale byte on second read, then recovery
        increment = 8'd1;
        increment_neg = 1'b0;
        load_addr(14'h0010);
        repeat (10) @(negedge clk);
        grant_en = 1'b0;
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("data_fb10", {24'h0, d}, 32'h90);
        repeat (3) @(negedge clk);
        chk("req_held", {31'h0, bif.fb_req}, 32'h1);
        chk("req_addr_11", {18'h0, bif.fb_addr}, 32'h11);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("stale_data", {24'h0, d}, 32'h90);
        chk("underrun_set", {31'h0, underrun}, 32'h1);
        repeat (20) @(negedge clk);
        grant_en = 1'b1;
        repeat (10) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("refill_fb12", {24'h0, d}, 32'h92);
        chk("underrun_sticky", {31'h0, underrun}, 32'h1);

        // addr_load while the 0x200 fetch sits in PF_WAIT
        repeat (10) @(negedge clk);
        load_addr(14'h0200);
        @(negedge clk);
        load_req = 1'b1;
        load_val = 14'h0100;
        @(negedge clk);
        load_req = 1'b0;
        repeat (10) @(negedge clk);
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("abort_fb100", {24'h0, d}, 32'hA5);

        // Register map with increment 0
        increment = 8'd0;
        load_addr(14'h0ABC);
        repeat (10) @(negedge clk);
        snap = adv_cnt;
        snap2 = req_cnt;
        for (int i = 0; i < 8; i++) begin
            cpu_cycle(tbl[i].r, 1'b1, d, dm, de);
            chk(tbl[i].name, {24'h0, d}, {24'h0, tbl[i].exp});
            chk({tbl[i].name, "_dir"}, {30'h0, dm, de}, 32'h1);
        end
        cpu_cycle(3'd3, 1'b1, d, dm, de);
        chk("inc0_same_byte", {24'h0, d}, 32'hBC);
        chk("inc0_no_adv", adv_cnt - snap, 0);
        chk("inc0_no_fetch", req_cnt - snap2, 0);

        // Write cycle leaves the bus undriven
        snap = dir0_cnt;
        cpu_cycle(3'd0, 1'b0, d, dm, de);
        chk("write_dir_hi", dir0_cnt - snap, 0);

        // Asynchronous reset mid-read
        @(negedge clk);
        bif.REG = 3'd0;
        bif.RW  = 1'b1;
        bif.EN  = 1'b0;
        @(negedge clk);
        bif.CLK_CPU = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_dir", {31'h0, bif.DIR}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dir", {31'h0, bif.DIR}, 32'h1);
        chk("async_rst_data", {24'h0, bif.DATA_OUT}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
